// File: rtl/arm_reg_scoreboard.sv
// Per-register pending-write scoreboard for the 5-stage ARM pipeline.
// ID records each issued register write, WB retires it, and the branch-flush
// path kills squashed writes. ID asks whether its source operands are still
// waiting on an in-flight write and receives a combinational stall request.
module arm_reg_scoreboard #(
  parameter int REG_W    = 4,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2,
  parameter int TOT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [REG_W-1:0]    issue_dest,
  output logic                issue_ready,
  input  logic                retire_valid,
  input  logic [REG_W-1:0]    retire_dest,
  input  logic                kill_valid,
  input  logic [REG_W-1:0]    kill_dest,
  input  logic [REG_W-1:0]    src1,
  input  logic [REG_W-1:0]    src2,
  input  logic                has_two_src,
  output logic                hazard_detected,
  output logic [NUM_REGS-1:0] pending,
  output logic [TOT_W-1:0]    outstanding,
  output logic                overflow_err,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [TOT_W-1:0]    outstanding_q, outstanding_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                issue_req;
  logic                inc_eff;
  logic                issue_hit_ret;
  logic                issue_hit_kill;
  logic                ret_src1, ret_src2;
  logic                busy_src1, busy_src2;

  // Issue admission: a saturated counter only accepts another write when a
  // retire or kill to the same register frees a slot on this same edge.
  always_comb begin
    issue_req      = issue_valid & issue_wb_en;
    issue_hit_ret  = retire_valid & (retire_dest == issue_dest);
    issue_hit_kill = kill_valid & (kill_dest == issue_dest);
    issue_ready    = !((cnt_q[issue_dest] == MAX_CNT) && !issue_hit_ret && !issue_hit_kill);
    inc_eff        = issue_req & issue_ready;
  end

  // Stall request: a source is busy if writes remain pending after any
  // same-cycle WB retire (WB forwards through the register file). Kills do
  // not count here, and the issuing instruction never hazards on itself.
  always_comb begin
    ret_src1        = retire_valid & (retire_dest == src1);
    ret_src2        = retire_valid & (retire_dest == src2);
    busy_src1       = cnt_q[src1] > CNT_W'(ret_src1);
    busy_src2       = cnt_q[src2] > CNT_W'(ret_src2);
    hazard_detected = busy_src1 | (has_two_src & busy_src2);
  end

  // Next-state for every counter plus the aggregate total and sticky errors.
  // Decrements are applied retire first, then kill; any decrement that would
  // go below zero is dropped on its own while the others still apply.
  always_comb begin : next_state
    logic [CNT_W:0] avail;
    logic [CNT_W:0] after_ret;
    logic [CNT_W:0] after_kill;
    logic           inc_r, ret_r, kill_r;
    logic           ret_ok, kill_ok;
    logic [1:0]     dec_total;
    logic           uflow;

    // NOTE: every variable gets a default before any conditional use so the
    // block stays purely combinational and no latch is inferred.
    avail      = '0;
    after_ret  = '0;
    after_kill = '0;
    inc_r      = 1'b0;
    ret_r      = 1'b0;
    kill_r     = 1'b0;
    ret_ok     = 1'b0;
    kill_ok    = 1'b0;
    dec_total  = '0;
    uflow      = 1'b0;
    pending_d  = '0;

    for (int r = 0; r < NUM_REGS; r++) begin
      inc_r  = inc_eff & (issue_dest == REG_W'(r));
      ret_r  = retire_valid & (retire_dest == REG_W'(r));
      kill_r = kill_valid & (kill_dest == REG_W'(r));

      // One extra bit absorbs a saturated count plus an issue that is
      // offset by a decrement to the same register.
      avail      = {1'b0, cnt_q[r]} + (CNT_W + 1)'(inc_r);
      ret_ok     = ret_r & (avail != '0);
      after_ret  = avail - (CNT_W + 1)'(ret_ok);
      kill_ok    = kill_r & (after_ret != '0);
      after_kill = after_ret - (CNT_W + 1)'(kill_ok);

      cnt_d[r]     = after_kill[CNT_W-1:0];
      pending_d[r] = (after_kill != '0);
      dec_total    = dec_total + 2'(ret_ok) + 2'(kill_ok);
      uflow        = uflow | (ret_r & ~ret_ok) | (kill_r & ~kill_ok);
    end

    outstanding_d = outstanding_q + TOT_W'(inc_eff) - TOT_W'(dec_total);
    overflow_d    = overflow_q | (issue_req & ~issue_ready);
    underflow_d   = underflow_q | uflow;
  end

  // State registers; reset forgets every in-flight write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the counter array is architectural state, not a data memory,
      // so each entry is reset explicitly to guarantee an empty scoreboard.
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      pending_q     <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign pending       = pending_q;
  assign outstanding   = outstanding_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule

// File: doc/arm_reg_scoreboard.md
Name: arm_reg_scoreboard

Overview:
- Per-register pending-write tracker for the 5-stage ARM pipeline.
- ID records each issued instruction that writes a register. WB retires the write. The branch-flush path kills squashed writes.
- ID queries the scoreboard with its source registers and gets a stall request.
- Replaces dest/WB_EN comparisons against the EXE and MEM stages, so the stall decision scales if stages are added.

Parameters:
REG_W, 4, register index width
NUM_REGS, 16, architectural registers tracked (R0-R15)
CNT_W, 2, per-register in-flight write counter width (max 2^CNT_W-1 = 3 in flight)
TOT_W, 6, width of total outstanding-write counter (holds NUM_REGS*(2^CNT_W-1) = 48)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
issue_valid  in  1  ID issues an instruction this cycle
issue_wb_en  in  1  issued instruction writes a register
issue_dest  in  REG_W  destination of issued instruction
issue_ready  out  1  combinational; 0 when counter of issue_dest is saturated
retire_valid  in  1  WB writes register file this cycle
retire_dest  in  REG_W  register written by WB
kill_valid  in  1  squashed in-flight write (branch flush), one per cycle
kill_dest  in  REG_W  destination of squashed write
src1  in  REG_W  ID source register 1
src2  in  REG_W  ID source register 2
has_two_src  in  1  src2 is a real operand
hazard_detected  out  1  combinational stall request to PC/IF-ID freeze and ID-EX bubble
pending  out  NUM_REGS  registered; bit i = counter i nonzero
outstanding  out  TOT_W  registered total of all counters
overflow_err  out  1  registered sticky: issue attempted at saturated counter
underflow_err  out  1  registered sticky: retire/kill at zero counter

Behaviour:
- Reset (rst=0, async):
  - all counters 0; pending=0, outstanding=0, overflow_err=0, underflow_err=0.
  - Combinational outputs then read issue_ready=1, hazard_detected=0.
- Effective issue: inc = issue_valid & issue_wb_en & issue_ready. Issue with issue_wb_en=0 changes nothing.
- Per-register next count: cnt[r] + inc(r) - dec_retire(r) - dec_kill(r), all applied in the same edge.
  - Issue+retire to the same reg in one cycle: net 0.
  - Retire+kill to the same reg: -2.
  - Issue+retire+kill to the same reg: -1.
- Underflow:
  - A decrement that would take a counter below 0 is dropped for that source.
  - Other simultaneous updates still apply; underflow_err sets.
  - Worked case: cnt=1 with retire and kill both targeting it -> apply retire, drop kill, cnt=0, underflow_err=1.
- Saturation:
  - issue_ready=0 when cnt[issue_dest]==max AND no retire/kill to issue_dest this cycle.
  - If issue_valid&issue_wb_en while issue_ready=0: counter unchanged, overflow_err sets.
- outstanding = sum of applied increments minus applied decrements. It always equals the sum of counters.
- hazard_detected = busy(src1) | (has_two_src & busy(src2)).
  - busy(r) = (cnt[r] > ret(r)), where ret(r) = retire_valid & retire_dest==r.
  - WB writes the register file on this edge and ID reads the written value, so a same-cycle retire of the last pending write does not stall.
  - Kills do not clear busy in their own cycle.
- No dependence on issue in the same cycle: an instruction never hazards on itself.
  - Worked case: issue_dest==src1 with cnt=0 -> hazard_detected=0.
- Sticky error flags clear only on reset.
- Reset asserted mid-operation: all state clears immediately; in-flight writes are forgotten. Pipeline registers reset together.

Test Plan:
1. Reset, then issue R3 (wb_en=1) at cycle 1. Cycle 2: src1=3 -> hazard_detected=1, pending=0x0008, outstanding=1. Retire R3 at cycle 4 with src1=3 -> hazard_detected=0 that cycle; pending=0 after the edge.
2. Issue R5 on three consecutive cycles -> cnt=3, issue_ready=0 on the next R5 issue.
   - Issue anyway -> cnt stays 3, overflow_err=1.
   - Same cycle with retire R5 -> issue_ready=1, cnt stays 3, no error.
3. cnt[R7]=1; retire R7 and kill R7 same cycle -> cnt=0, outstanding decrements by 1, underflow_err=1.
4. Issue R2 and R4, src1=0, src2=4:
   - has_two_src=0 -> hazard_detected=0.
   - has_two_src=1 -> hazard_detected=1.
5. Issue R1, R1, R9 (outstanding=3); assert rst low mid-cycle -> pending=0, outstanding=0 asynchronously; after release, src1=1 -> hazard_detected=0.
6. Random issue/retire/kill stream for 10k cycles against a reference model -> outstanding == popcount-weighted counter sum every cycle, no spurious errors when the stream is legal.
